// File: rtl/tile_sched.sv
// tile_sched: frame-level tile scheduler for the tile renderer.
//
// Walks the screen in raster order, one tile at a time. For each tile it clears a tile
// buffer, rasterizes into it and hands it to the tile writer. Two buffers alternate, so
// the next tile is cleared and rasterized while the previous one is written back.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   frame_start_i         pulse: render one frame (ignored while frame_busy_o)
//   frame_busy_o          high from the accepted frame_start_i until frame_done_o
//   frame_done_o          pulse after the last tile has been written back
//   clr_start_o/clr_buf_o, clr_done_i                  clear engine handshake
//   rast_start_o/rast_buf_o/rast_px_o/rast_py_o, rast_done_i  rasterizer handshake
//   wb_start_o/wb_buf_o/wb_px_o/wb_py_o, wb_done_i      tile writer handshake
// All outputs are registered. Index and coordinate outputs hold from a start pulse until
// the matching done pulse.
module tile_sched #(
  parameter int unsigned TILES_X    = 20,
  parameter int unsigned TILES_Y    = 15,
  parameter int unsigned TILE_SHIFT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start_i,
  output logic        frame_busy_o,
  output logic        frame_done_o,
  output logic        clr_start_o,
  output logic        clr_buf_o,
  input  logic        clr_done_i,
  output logic        rast_start_o,
  output logic        rast_buf_o,
  output logic [15:0] rast_px_o,
  output logic [15:0] rast_py_o,
  input  logic        rast_done_i,
  output logic        wb_start_o,
  output logic        wb_buf_o,
  output logic [15:0] wb_px_o,
  output logic [15:0] wb_py_o,
  input  logic        wb_done_i
);

  localparam logic [15:0] NumTiles = 16'(TILES_X * TILES_Y);
  localparam logic [15:0] LastTx   = 16'(TILES_X - 1);
  localparam logic [15:0] LastTy   = 16'(TILES_Y - 1);

  typedef enum logic [1:0] {RIdle, RWait, RClear, RRast} r_state_e;
  typedef enum logic {WIdle, WBusy} w_state_e;

  r_state_e         r_state_q, r_state_d;
  w_state_e         w_state_q, w_state_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;
  logic             clr_start_q, clr_start_d;
  logic             clr_buf_q, clr_buf_d;
  logic             rast_start_q, rast_start_d;
  logic             rast_buf_q, rast_buf_d;
  logic [15:0]      rast_px_q, rast_px_d;
  logic [15:0]      rast_py_q, rast_py_d;
  logic             wb_start_q, wb_start_d;
  logic             wb_buf_q, wb_buf_d;
  logic [15:0]      wb_px_q, wb_px_d;
  logic [15:0]      wb_py_q, wb_py_d;
  logic [1:0]       full_q, full_d;
  logic [1:0][15:0] px_q, px_d;
  logic [1:0][15:0] py_q, py_d;
  logic             rb_q, rb_d;
  logic             wbp_q, wbp_d;
  logic [15:0]      tx_q, tx_d;
  logic [15:0]      ty_q, ty_d;
  logic [15:0]      tiles_left_q, tiles_left_d;

  always_comb begin
    r_state_d    = r_state_q;
    w_state_d    = w_state_q;
    frame_busy_d = frame_busy_q;
    frame_done_d = 1'b0;
    clr_start_d  = 1'b0;
    clr_buf_d    = clr_buf_q;
    rast_start_d = 1'b0;
    rast_buf_d   = rast_buf_q;
    rast_px_d    = rast_px_q;
    rast_py_d    = rast_py_q;
    wb_start_d   = 1'b0;
    wb_buf_d     = wb_buf_q;
    wb_px_d      = wb_px_q;
    wb_py_d      = wb_py_q;
    full_d       = full_q;
    px_d         = px_q;
    py_d         = py_q;
    rb_d         = rb_q;
    wbp_d        = wbp_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    tiles_left_d = tiles_left_q;

    // Render side: clear -> rasterize, one tile at a time.
    unique case (r_state_q)
      RIdle: begin
        // The render side may already be idle while the last tiles drain; a new frame is
        // only taken once the whole previous frame has been written back.
        if (frame_start_i && !frame_busy_q) begin
          frame_busy_d = 1'b1;
          tx_d         = '0;
          ty_d         = '0;
          rb_d         = 1'b0;
          wbp_d        = 1'b0;
          full_d       = '0;
          tiles_left_d = NumTiles;
          // Both buffers are free on a fresh frame, so the first clear goes out at once.
          clr_start_d  = 1'b1;
          clr_buf_d    = 1'b0;
          r_state_d    = RClear;
        end
      end
      RWait: begin
        if (!full_q[rb_q]) begin
          clr_start_d = 1'b1;
          clr_buf_d   = rb_q;
          r_state_d   = RClear;
        end
      end
      RClear: begin
        if (clr_done_i) begin
          rast_start_d = 1'b1;
          rast_buf_d   = rb_q;
          rast_px_d    = tx_q << TILE_SHIFT;
          rast_py_d    = ty_q << TILE_SHIFT;
          r_state_d    = RRast;
        end
      end
      RRast: begin
        if (rast_done_i) begin
          full_d[rb_q] = 1'b1;
          px_d[rb_q]   = rast_px_q;
          py_d[rb_q]   = rast_py_q;
          rb_d         = ~rb_q;
          if (tx_q == LastTx) begin
            tx_d = '0;
            ty_d = ty_q + 16'd1;
          end else begin
            tx_d = tx_q + 16'd1;
          end
          r_state_d = (tx_q == LastTx && ty_q == LastTy) ? RIdle : RWait;
        end
      end
      default: r_state_d = RIdle;
    endcase

    // Writeback side: drains full buffers in the order they were filled. It never
    // touches the buffer the render side is filling, so the two full_d updates below
    // and above always hit different bits.
    unique case (w_state_q)
      WIdle: begin
        if (frame_busy_q && full_q[wbp_q]) begin
          wb_start_d = 1'b1;
          wb_buf_d   = wbp_q;
          wb_px_d    = px_q[wbp_q];
          wb_py_d    = py_q[wbp_q];
          w_state_d  = WBusy;
        end
      end
      WBusy: begin
        if (wb_done_i) begin
          full_d[wbp_q] = 1'b0;
          wbp_d         = ~wbp_q;
          tiles_left_d  = tiles_left_q - 16'd1;
          if (tiles_left_q == 16'd1) begin
            frame_done_d = 1'b1;
            frame_busy_d = 1'b0;
          end
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q    <= RIdle;
      w_state_q    <= WIdle;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      clr_start_q  <= 1'b0;
      clr_buf_q    <= 1'b0;
      rast_start_q <= 1'b0;
      rast_buf_q   <= 1'b0;
      rast_px_q    <= '0;
      rast_py_q    <= '0;
      wb_start_q   <= 1'b0;
      wb_buf_q     <= 1'b0;
      wb_px_q      <= '0;
      wb_py_q      <= '0;
      full_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      rb_q         <= 1'b0;
      wbp_q        <= 1'b0;
      tx_q         <= '0;
      ty_q         <= '0;
      tiles_left_q <= '0;
    end else begin
      r_state_q    <= r_state_d;
      w_state_q    <= w_state_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
      clr_start_q  <= clr_start_d;
      clr_buf_q    <= clr_buf_d;
      rast_start_q <= rast_start_d;
      rast_buf_q   <= rast_buf_d;
      rast_px_q    <= rast_px_d;
      rast_py_q    <= rast_py_d;
      wb_start_q   <= wb_start_d;
      wb_buf_q     <= wb_buf_d;
      wb_px_q      <= wb_px_d;
      wb_py_q      <= wb_py_d;
      full_q       <= full_d;
      px_q         <= px_d;
      py_q         <= py_d;
      rb_q         <= rb_d;
      wbp_q        <= wbp_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      tiles_left_q <= tiles_left_d;
    end
  end

  assign frame_busy_o = frame_busy_q;
  assign frame_done_o = frame_done_q;
  assign clr_start_o  = clr_start_q;
  assign clr_buf_o    = clr_buf_q;
  assign rast_start_o = rast_start_q;
  assign rast_buf_o   = rast_buf_q;
  assign rast_px_o    = rast_px_q;
  assign rast_py_o    = rast_py_q;
  assign wb_start_o   = wb_start_q;
  assign wb_buf_o     = wb_buf_q;
  assign wb_px_o      = wb_px_q;
  assign wb_py_o      = wb_py_q;

endmodule

// File: tb/tb_tile_sched.sv
// Testbench for tile_sched. Sub-block responders answer start pulses after programmable
// latencies; a scoreboard holds the expected clear/raster/writeback sequence of a frame
// and a monitor pops and compares on every start pulse.
module tb_tile_sched;

  localparam int NT = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        frame_busy, frame_done;
  logic        clr_start, clr_buf, clr_done;
  logic        rast_start, rast_buf, rast_done;
  logic [15:0] rast_px, rast_py;
  logic        wb_start, wb_buf, wb_done;
  logic [15:0] wb_px, wb_py;

  tile_sched dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start_i(frame_start),
    .frame_busy_o (frame_busy),
    .frame_done_o (frame_done),
    .clr_start_o  (clr_start),
    .clr_buf_o    (clr_buf),
    .clr_done_i   (clr_done),
    .rast_start_o (rast_start),
    .rast_buf_o   (rast_buf),
    .rast_px_o    (rast_px),
    .rast_py_o    (rast_py),
    .rast_done_i  (rast_done),
    .wb_start_o   (wb_start),
    .wb_buf_o     (wb_buf),
    .wb_px_o      (wb_px),
    .wb_py_o      (wb_py),
    .wb_done_i    (wb_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues and logs.
  logic        exp_clr[$];
  logic [32:0] exp_rast[$];
  logic [32:0] exp_wb[$];
  int clr_cyc_q[$], wb_cyc_q[$], rast_done_q[$], wb_done_q[$];
  int n_clr, n_rast, n_wb, n_done;
  int n_rast_done, n_wb_done;
  int clr_done_last, wb_done_last;
  logic [1:0] model_full;

  // Responder configuration.
  int lat_clr = 3, lat_rast = 3, lat_wb = 3;
  bit spur_en = 1'b0;

  // Monitor: samples registered outputs on the falling edge.
  always @(negedge clk) begin
    if (clr_start) begin
      n_clr++;
      clr_cyc_q.push_back(cyc);
      chk("clr_to_full_buffer", model_full[clr_buf], 1'b0);
      chk("clr_expected", exp_clr.size() != 0, 1'b1);
      if (exp_clr.size() != 0) chk("clr_buf", clr_buf, exp_clr.pop_front());
    end
    if (rast_start) begin
      n_rast++;
      chk("rast_latency", cyc, clr_done_last + 1);
      chk("rast_expected", exp_rast.size() != 0, 1'b1);
      if (exp_rast.size() != 0) chk("rast_buf_px_py", {rast_buf, rast_px, rast_py},
                                    exp_rast.pop_front());
    end
    if (wb_start) begin
      n_wb++;
      wb_cyc_q.push_back(cyc);
      chk("wb_expected", exp_wb.size() != 0, 1'b1);
      if (exp_wb.size() != 0) chk("wb_buf_px_py", {wb_buf, wb_px, wb_py}, exp_wb.pop_front());
    end
    if (frame_done) n_done++;
  end

  // Responders: done pulses a fixed number of cycles after each start pulse. Buffer
  // occupancy is modelled from completion order (tile i always lives in buffer i%2).
  initial begin
    int c_clr, c_rast, c_wb, c_spur;
    c_clr = 0; c_rast = 0; c_wb = 0; c_spur = 0;
    clr_done = 1'b0; rast_done = 1'b0; wb_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      clr_done = 1'b0; rast_done = 1'b0; wb_done = 1'b0;
      if (clr_start) c_clr = lat_clr;
      else if (c_clr > 0) begin
        c_clr--;
        if (c_clr == 0) begin clr_done = 1'b1; clr_done_last = cyc; end
      end
      if (c_spur > 0) begin
        c_spur--;
        if (c_spur == 0) clr_done = 1'b1;
      end
      if (rast_start) begin
        c_rast = lat_rast;
        if (spur_en) c_spur = 1;
      end else if (c_rast > 0) begin
        c_rast--;
        if (c_rast == 0) begin
          rast_done = 1'b1;
          model_full[n_rast_done % 2] = 1'b1;
          n_rast_done++;
          rast_done_q.push_back(cyc);
        end
      end
      if (wb_start) c_wb = lat_wb;
      else if (c_wb > 0) begin
        c_wb--;
        if (c_wb == 0) begin
          wb_done = 1'b1;
          model_full[n_wb_done % 2] = 1'b0;
          n_wb_done++;
          wb_done_q.push_back(cyc);
          wb_done_last = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic clear_logs();
    clr_cyc_q.delete(); wb_cyc_q.delete(); rast_done_q.delete(); wb_done_q.delete();
    n_clr = 0; n_rast = 0; n_wb = 0; n_done = 0;
    n_rast_done = 0; n_wb_done = 0;
    model_full = 2'b00;
  endtask

  task automatic push_frame();
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < 20; x++) begin
        logic b;
        logic [15:0] px, py;
        b  = ((y * 20 + x) % 2) == 1;
        px = 16'(x * 32);
        py = 16'(y * 32);
        exp_clr.push_back(b);
        exp_rast.push_back({b, px, py});
        exp_wb.push_back({b, px, py});
      end
    end
  endtask

  // Starts a frame, optionally pokes frame_start again mid-frame, waits for frame_done.
  task automatic run_frame(input int poke_at, input int limit);
    bit seen;
    clear_logs();
    push_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("busy_after_start", frame_busy, 1'b1);
    chk("clr_after_start", clr_start, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      frame_start = (i == poke_at);
      if (frame_done) begin
        seen = 1'b1;
        chk("done_after_last_wb", cyc, wb_done_last + 1);
        chk("busy_low_at_done", frame_busy, 1'b0);
      end
    end
    frame_start = 1'b0;
    chk("frame_completed", seen, 1'b1);
    tick();
    chk("done_one_cycle", frame_done, 1'b0);
    chk("clr_count", n_clr, NT);
    chk("rast_count", n_rast, NT);
    chk("wb_count", n_wb, NT);
    chk("done_count", n_done, 1);
    chk("sb_clr_drained", exp_clr.size(), 0);
    chk("sb_rast_drained", exp_rast.size(), 0);
    chk("sb_wb_drained", exp_wb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    clear_logs();
    clr_done_last = 0;
    wb_done_last = 0;
    repeat (3) tick();
    chk("reset_ctl", {frame_busy, frame_done, clr_start, clr_buf, rast_start, rast_buf,
                      wb_start, wb_buf}, 0);
    chk("reset_coords", {rast_px, rast_py, wb_px, wb_py}, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", frame_busy, 1'b0);

    // Fast sub-blocks, a spurious clr_done during every raster pass, and a frame_start
    // pulse while busy.
    spur_en = 1'b1;
    run_frame(100, 5000);
    spur_en = 1'b0;
    chk("wb0_after_rast0", wb_cyc_q[0], rast_done_q[0] + 2);
    chk("clr1_after_rast0", clr_cyc_q[1], rast_done_q[0] + 2);

    // Slow writer: render stalls with both buffers full.
    lat_wb = 100;
    run_frame(-1, 40000);
    chk("stall_both_full", (clr_cyc_q[2] - rast_done_q[1]) > 2, 1'b1);
    chk("clr2_after_wbdone0", clr_cyc_q[2], wb_done_q[0] + 2);
    chk("wb1_after_wbdone0", wb_cyc_q[1], wb_done_q[0] + 2);

    // rast_done and wb_done land in the same cycle on different buffers.
    lat_wb = 7;
    run_frame(-1, 5000);
    chk("coincide_0", rast_done_q[1], wb_done_q[0]);
    chk("coincide_clr2", clr_cyc_q[2], wb_done_q[0] + 2);
    chk("coincide_wb1", wb_cyc_q[1], wb_done_q[0] + 2);
    chk("coincide_100", rast_done_q[101], wb_done_q[100]);
    chk("coincide_clr102", clr_cyc_q[102], wb_done_q[100] + 2);
    lat_wb = 3;

    // Reset after tile 57 is rasterized, then a clean restart.
    clear_logs();
    push_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 2000 && n_rast_done < 57; i++) tick();
    chk("reached_tile57", n_rast_done, 57);
    reset = 1'b1;
    tick();
    chk("midrst_ctl", {frame_busy, frame_done, clr_start, clr_buf, rast_start, rast_buf,
                       wb_start, wb_buf}, 0);
    chk("midrst_coords", {rast_px, rast_py, wb_px, wb_py}, 0);
    reset = 1'b0;
    exp_clr.delete(); exp_rast.delete(); exp_wb.delete();
    repeat (10) tick();
    chk("idle_after_midrst", frame_busy, 1'b0);
    run_frame(-1, 5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
